// File: rtl/rd_wr_sb_unit.sv
// Register file with a busy scoreboard, RAW/WAW issue stall and a writeback bypass.
// Ports: clk, rst (async, active-low)
//   issue_*  : decode-side request (two sources, one destination)
//   stall    : issue not accepted this cycle
//   rd1/rd2  : combinational read data (bypassed from writeback)
//   wb_*     : writeback retire (skip/dirty suppress the data write)
//   flush    : drop every pending producer
//   busy_vec : pending-producer bit per register
//   pend_cnt : popcount of busy_vec
module rd_wr_sb_unit #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_valid,
   input  logic [ADDR_W-1:0]       issue_rreg1,
   input  logic [ADDR_W-1:0]       issue_rreg2,
   input  logic                    issue_use1,
   input  logic                    issue_use2,
   input  logic                    issue_wr,
   input  logic [ADDR_W-1:0]       issue_wreg,
   output logic                    stall,
   output logic [DATA_W-1:0]       rd1,
   output logic [DATA_W-1:0]       rd2,
   input  logic                    wb_valid,
   input  logic                    wb_skip,
   input  logic                    wb_dirty,
   input  logic [ADDR_W-1:0]       wb_reg,
   input  logic [DATA_W-1:0]       wb_data,
   input  logic                    flush,
   output logic [(1<<ADDR_W)-1:0]  busy_vec,
   output logic [ADDR_W:0]         pend_cnt
);

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [NREGS-1:0]  r_busy;
   logic [ADDR_W:0]   r_cnt;

   logic              w_commit;
   logic              w_clear;
   logic              w_stall;
   logic              w_accept;
   logic              w_wb_zero;
   logic [NREGS-1:0]  w_clr_mask;
   logic [NREGS-1:0]  w_set_mask;
   logic [NREGS-1:0]  w_zmask;
   logic [NREGS-1:0]  w_eff_busy;
   logic [NREGS-1:0]  w_busy_nxt;
   logic [ADDR_W:0]   w_cnt_nxt;

   // Gating with rst keeps the bypass and stall quiet while reset is held.
   assign w_commit  = rst & wb_valid & ~wb_skip & ~wb_dirty;
   assign w_clear   = wb_valid;
   assign w_wb_zero = ZERO_REG && (wb_reg == '0);
   assign w_zmask   = ZERO_REG ? NREGS'(1) : '0;

   assign w_clr_mask = w_clear ? (NREGS'(1) << wb_reg) : '0;
   // A retire in this cycle resolves the hazard on its register.
   assign w_eff_busy = r_busy & ~w_clr_mask;

   assign w_stall = rst & issue_valid & ~flush &
                    ((issue_use1 & w_eff_busy[issue_rreg1]) |
                     (issue_use2 & w_eff_busy[issue_rreg2]) |
                     (issue_wr   & w_eff_busy[issue_wreg]));

   assign w_accept   = issue_valid & ~w_stall & ~flush;
   assign w_set_mask = (w_accept & issue_wr) ?
                       (NREGS'(1) << issue_wreg) : '0;

   // Set is OR-ed after the clear so a same-cycle set/clear leaves the bit 1.
   always_comb begin
      w_busy_nxt = '0;
      if (!flush) begin
         w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~w_zmask;
      end
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit && !w_wb_zero) begin
         r_regs[wb_reg] <= wb_data;
      end
   end

   always_comb begin
      rd1 = r_regs[issue_rreg1];
      if (w_commit && (wb_reg == issue_rreg1)) begin
         rd1 = wb_data;
      end
      if (ZERO_REG && (issue_rreg1 == '0)) begin
         rd1 = '0;
      end
   end

   always_comb begin
      rd2 = r_regs[issue_rreg2];
      if (w_commit && (wb_reg == issue_rreg2)) begin
         rd2 = wb_data;
      end
      if (ZERO_REG && (issue_rreg2 == '0)) begin
         rd2 = '0;
      end
   end

   assign stall    = w_stall;
   assign busy_vec = r_busy;
   assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_rd_wr_sb_unit.sv
// Bench for rd_wr_sb_unit: one instance per ZERO_REG setting, a table of
// hand-derived vectors, reset sequences and randomized traffic against a model.
module tb_rd_wr_sb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_use1, issue_use2, issue_wr;
   logic [2:0]  issue_rreg1, issue_rreg2, issue_wreg;
   logic        wb_valid, wb_skip, wb_dirty, flush;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;

   logic        stall0, stall1;
   logic [15:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic [7:0]  busy0, busy1;
   logic [3:0]  cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rd_wr_sb_unit #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u0 (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rreg1(issue_rreg1),
      .issue_rreg2(issue_rreg2), .issue_use1(issue_use1),
      .issue_use2(issue_use2), .issue_wr(issue_wr),
      .issue_wreg(issue_wreg), .stall(stall0),
      .rd1(rd1_0), .rd2(rd2_0),
      .wb_valid(wb_valid), .wb_skip(wb_skip), .wb_dirty(wb_dirty),
      .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
      .busy_vec(busy0), .pend_cnt(cnt0)
   );

   rd_wr_sb_unit #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u1 (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rreg1(issue_rreg1),
      .issue_rreg2(issue_rreg2), .issue_use1(issue_use1),
      .issue_use2(issue_use2), .issue_wr(issue_wr),
      .issue_wreg(issue_wreg), .stall(stall1),
      .rd1(rd1_1), .rd2(rd2_1),
      .wb_valid(wb_valid), .wb_skip(wb_skip), .wb_dirty(wb_dirty),
      .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
      .busy_vec(busy1), .pend_cnt(cnt1)
   );

   typedef struct {
      logic        iv, u1, u2, wr, wv, sk, dt, fl;
      logic [2:0]  r1, r2, wreg, wbr;
      logic [15:0] wd;
      logic        es;
      logic [15:0] e1, e2;
      logic [7:0]  eb;
      logic [3:0]  ec;
   } vec_t;

   vec_t tbl [26];
   vec_t cur;
   bit   tchk = 1'b0;

   // Model state: index 0 = ZERO_REG 0, index 1 = ZERO_REG 1
   logic [15:0] mr [2][8];
   bit          mb [2][8];

   function automatic vec_t v(
      input logic iv, u1, input logic [2:0] r1,
      input logic u2, input logic [2:0] r2,
      input logic wr, input logic [2:0] wreg,
      input logic wv, sk, dt, input logic [2:0] wbr,
      input logic [15:0] wd, input logic fl,
      input logic es, input logic [15:0] e1, e2,
      input logic [7:0] eb, input logic [3:0] ec);
      vec_t t;
      t.iv = iv; t.u1 = u1; t.r1 = r1; t.u2 = u2; t.r2 = r2;
      t.wr = wr; t.wreg = wreg; t.wv = wv; t.sk = sk; t.dt = dt;
      t.wbr = wbr; t.wd = wd; t.fl = fl;
      t.es = es; t.e1 = e1; t.e2 = e2; t.eb = eb; t.ec = ec;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      issue_valid = t.iv; issue_use1 = t.u1; issue_rreg1 = t.r1;
      issue_use2 = t.u2; issue_rreg2 = t.r2;
      issue_wr = t.wr; issue_wreg = t.wreg;
      wb_valid = t.wv; wb_skip = t.sk; wb_dirty = t.dt;
      wb_reg = t.wbr; wb_data = t.wd; flush = t.fl;
   endtask

   task automatic idle();
      issue_valid = 0; issue_use1 = 0; issue_use2 = 0; issue_wr = 0;
      issue_rreg1 = 0; issue_rreg2 = 0; issue_wreg = 0;
      wb_valid = 0; wb_skip = 0; wb_dirty = 0; wb_reg = 0;
      wb_data = 0; flush = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic bit mcommit();
      return wb_valid && !wb_skip && !wb_dirty;
   endfunction

   function automatic logic [15:0] mread(input int z, input int idx);
      if (z == 1 && idx == 0) return 16'h0;
      if (mcommit() && int'(wb_reg) == idx) return wb_data;
      return mr[z][idx];
   endfunction

   function automatic bit meff(input int z, input int r);
      return mb[z][r] && !(wb_valid && int'(wb_reg) == r);
   endfunction

   function automatic bit mstall(input int z);
      if (!rst) return 1'b0;
      return issue_valid && !flush &&
             ((issue_use1 && meff(z, int'(issue_rreg1))) ||
              (issue_use2 && meff(z, int'(issue_rreg2))) ||
              (issue_wr   && meff(z, int'(issue_wreg))));
   endfunction

   task automatic mcheck(input int z, input logic s, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [7:0] b,
                         input logic [3:0] c);
      logic [15:0] e1, e2;
      logic [7:0]  eb;
      int          ec;
      string       p;
      p = (z == 0) ? "z0" : "z1";
      e1 = 0; e2 = 0; eb = 0; ec = 0;
      if (rst) begin
         e1 = mread(z, int'(issue_rreg1));
         e2 = mread(z, int'(issue_rreg2));
         for (int r = 0; r < 8; r++) begin
            eb[r] = mb[z][r];
            ec += int'(mb[z][r]);
         end
      end
      chk({p, ".stall"}, {31'b0, s}, {31'b0, mstall(z)});
      chk({p, ".rd1"}, {16'b0, a1}, {16'b0, e1});
      chk({p, ".rd2"}, {16'b0, a2}, {16'b0, e2});
      chk({p, ".busy_vec"}, {24'b0, b}, {24'b0, eb});
      chk({p, ".pend_cnt"}, {28'b0, c}, ec);
   endtask

   task automatic mupd(input int z);
      bit st, acc;
      if (!rst) begin
         for (int r = 0; r < 8; r++) begin
            mr[z][r] = 0;
            mb[z][r] = 0;
         end
         return;
      end
      st  = mstall(z);
      acc = issue_valid && !st && !flush;
      if (mcommit() && !(z == 1 && wb_reg == 0)) mr[z][wb_reg] = wb_data;
      if (flush) begin
         for (int r = 0; r < 8; r++) mb[z][r] = 0;
      end else begin
         if (wb_valid) mb[z][wb_reg] = 0;
         if (acc && issue_wr && !(z == 1 && issue_wreg == 0))
            mb[z][issue_wreg] = 1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      mcheck(0, stall0, rd1_0, rd2_0, busy0, cnt0);
      mcheck(1, stall1, rd1_1, rd2_1, busy1, cnt1);
      if (tchk) begin
         chk("tbl.stall", {31'b0, stall1}, {31'b0, cur.es});
         chk("tbl.rd1", {16'b0, rd1_1}, {16'b0, cur.e1});
         chk("tbl.rd2", {16'b0, rd2_1}, {16'b0, cur.e2});
         chk("tbl.busy_vec", {24'b0, busy1}, {24'b0, cur.eb});
         chk("tbl.pend_cnt", {28'b0, cnt1}, {28'b0, cur.ec});
      end
      @(posedge clk);
      mupd(0);
      mupd(1);
      #1;
   endtask

   initial begin
      int bl [$];
      // expected values are for the ZERO_REG=1 instance
      tbl[0]  = v(0,0,3,0,5,0,0, 0,0,0,0,16'h0000,0, 0,16'h0000,16'h0000,8'h00,0);
      tbl[1]  = v(0,0,2,0,5,0,0, 1,0,0,2,16'hBEEF,0, 0,16'hBEEF,16'h0000,8'h00,0);
      tbl[2]  = v(0,0,2,0,5,0,0, 0,0,0,0,16'h0000,0, 0,16'hBEEF,16'h0000,8'h00,0);
      tbl[3]  = v(1,0,2,0,5,1,4, 0,0,0,0,16'h0000,0, 0,16'hBEEF,16'h0000,8'h00,0);
      tbl[4]  = v(0,0,4,0,5,0,0, 1,1,0,4,16'h1234,0, 0,16'h0000,16'h0000,8'h10,1);
      tbl[5]  = v(0,0,4,0,2,0,0, 1,0,1,2,16'h5555,0, 0,16'h0000,16'hBEEF,8'h00,0);
      tbl[6]  = v(1,0,2,0,2,1,1, 0,0,0,0,16'h0000,0, 0,16'hBEEF,16'hBEEF,8'h00,0);
      tbl[7]  = v(1,1,1,0,0,0,0, 0,0,0,0,16'h0000,0, 1,16'h0000,16'h0000,8'h02,1);
      tbl[8]  = v(1,1,1,0,0,0,0, 0,0,0,0,16'h0000,0, 1,16'h0000,16'h0000,8'h02,1);
      tbl[9]  = v(1,1,1,0,0,0,0, 1,0,0,1,16'h00A5,0, 0,16'h00A5,16'h0000,8'h02,1);
      tbl[10] = v(1,0,1,0,0,1,6, 0,0,0,0,16'h0000,0, 0,16'h00A5,16'h0000,8'h00,0);
      tbl[11] = v(1,0,1,0,6,1,6, 1,0,0,6,16'h0666,0, 0,16'h00A5,16'h0666,8'h40,1);
      tbl[12] = v(0,0,6,0,0,0,0, 0,0,0,0,16'h0000,0, 0,16'h0666,16'h0000,8'h40,1);
      tbl[13] = v(1,0,6,0,0,1,3, 1,0,0,6,16'h0777,0, 0,16'h0777,16'h0000,8'h40,1);
      tbl[14] = v(1,0,6,0,0,1,5, 0,0,0,0,16'h0000,0, 0,16'h0777,16'h0000,8'h08,1);
      tbl[15] = v(1,0,4,0,0,1,2, 1,0,0,4,16'h4444,1, 0,16'h4444,16'h0000,8'h28,2);
      tbl[16] = v(0,0,4,0,0,0,0, 0,0,0,0,16'h0000,0, 0,16'h4444,16'h0000,8'h00,0);
      tbl[17] = v(1,0,4,0,0,1,0, 0,0,0,0,16'h0000,0, 0,16'h4444,16'h0000,8'h00,0);
      tbl[18] = v(0,0,0,0,0,0,0, 1,0,0,0,16'hFFFF,0, 0,16'h0000,16'h0000,8'h00,0);
      tbl[19] = v(0,0,0,0,0,0,0, 0,0,0,0,16'h0000,0, 0,16'h0000,16'h0000,8'h00,0);
      tbl[20] = v(0,0,0,0,5,0,0, 1,0,0,5,16'h5A5A,0, 0,16'h0000,16'h5A5A,8'h00,0);
      tbl[21] = v(0,0,0,0,5,0,0, 0,0,0,0,16'h0000,0, 0,16'h0000,16'h5A5A,8'h00,0);
      tbl[22] = v(1,0,0,0,5,1,3, 0,0,0,0,16'h0000,0, 0,16'h0000,16'h5A5A,8'h00,0);
      tbl[23] = v(1,0,0,0,5,1,3, 0,0,0,0,16'h0000,0, 1,16'h0000,16'h5A5A,8'h08,1);
      tbl[24] = v(1,0,0,1,3,0,0, 1,0,1,3,16'h1111,0, 0,16'h0000,16'h0000,8'h08,1);
      tbl[25] = v(0,0,0,0,3,0,0, 0,0,0,0,16'h0000,0, 0,16'h0000,16'h0000,8'h00,0);

      for (int z = 0; z < 2; z++)
         for (int r = 0; r < 8; r++) begin
            mr[z][r] = 0;
            mb[z][r] = 0;
         end

      // reset held with live traffic: outputs must still read as idle
      idle();
      rst = 1'b0;
      issue_valid = 1; issue_use1 = 1; issue_rreg1 = 3; issue_rreg2 = 5;
      issue_wr = 1; issue_wreg = 3;
      wb_valid = 1; wb_reg = 3; wb_data = 16'hDEAD;
      cycle();
      cycle();
      idle();
      rst = 1'b1;

      for (int i = 0; i < 26; i++) begin
         apply(tbl[i]);
         cur  = tbl[i];
         tchk = 1'b1;
         cycle();
         tchk = 1'b0;
      end

      // reset in the middle of pending producers
      idle();
      issue_valid = 1; issue_wr = 1; issue_wreg = 2;
      cycle();
      issue_wreg = 7;
      cycle();
      chk("mid.pend_before", {28'b0, cnt1}, 32'd2);
      idle();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      chk("mid.busy_after", {24'b0, busy0}, 32'd0);
      wb_valid = 1; wb_reg = 2; wb_data = 16'h2222; issue_rreg1 = 2;
      cycle();
      idle();
      issue_rreg1 = 2;
      cycle();
      chk("mid.stale_data", {16'b0, rd1_1}, 32'h2222);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         idle();
         issue_valid = ($urandom_range(0, 9) < 7);
         issue_use1  = $urandom_range(0, 1);
         issue_use2  = $urandom_range(0, 1);
         issue_wr    = $urandom_range(0, 1);
         issue_rreg1 = 3'($urandom_range(0, 7));
         issue_rreg2 = 3'($urandom_range(0, 7));
         issue_wreg  = 3'($urandom_range(0, 7));
         wb_valid    = $urandom_range(0, 1);
         wb_skip     = ($urandom_range(0, 7) == 0);
         wb_dirty    = ($urandom_range(0, 7) == 0);
         wb_data     = 16'($urandom);
         flush       = ($urandom_range(0, 29) == 0);
         bl.delete();
         for (int r = 0; r < 8; r++) if (mb[0][r]) bl.push_back(r);
         if (bl.size() > 0 && $urandom_range(0, 9) < 7)
            wb_reg = 3'(bl[$urandom_range(0, bl.size() - 1)]);
         else
            wb_reg = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) issue_rreg1 = wb_reg;
         if ($urandom_range(0, 3) == 0) issue_wreg = wb_reg;
         if ($urandom_range(0, 199) == 0) rst = 1'b0;
         cycle();
         rst = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rd_wr_sb_unit.md
Name: rd_wr_sb_unit

Overview:
Parametrised register read/write unit with an integrated scoreboard. It is the next-generation replacement for the plain skip/dirty-protected register access unit. It holds the architectural register file and tracks which registers have an in-flight producer. Decode is stalled on RAW/WAW hazards, and writeback data is bypassed to the read ports in the same cycle. It sits between decode (issue side) and writeback.

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 3, register index width; register count NREGS = 2**ADDR_W (derived, not overridable)
ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, writes dropped, never busy)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
issue_valid  in  1  decode presents an instruction
issue_rreg1  in  ADDR_W  source register 1 index
issue_rreg2  in  ADDR_W  source register 2 index
issue_use1  in  1  instruction reads rreg1
issue_use2  in  1  instruction reads rreg2
issue_wr  in  1  instruction will write a register
issue_wreg  in  ADDR_W  destination register index
stall  out  1  issue not accepted this cycle
rd1  out  DATA_W  read data port 1 (combinational)
rd2  out  DATA_W  read data port 2 (combinational)
wb_valid  in  1  writeback slot retires a producer
wb_skip  in  1  instruction annulled; no register write
wb_dirty  in  1  protection fault; no register write
wb_reg  in  ADDR_W  writeback register index
wb_data  in  DATA_W  writeback data
flush  in  1  pipeline flush; drop all pending producers
busy_vec  out  NREGS  per-register pending-producer bits
pend_cnt  out  ADDR_W+1  number of set busy bits

Behaviour:
- Reset (rst low, asynchronous): all registers = 0, busy_vec = 0, pend_cnt = 0. Outputs are valid during reset: rd1/rd2 = 0 and stall = 0.
- commit = wb_valid & !wb_skip & !wb_dirty. On commit, regs[wb_reg] <= wb_data at the clock edge.
- clear = wb_valid, regardless of skip/dirty. It clears busy[wb_reg] at the edge.
- Reads are combinational. rdN = wb_data if commit and wb_reg == issue_rregN (write-through bypass); otherwise rdN = regs[issue_rregN]. With ZERO_REG=1, index 0 always reads 0, including when bypassing.
- Busy test: eff_busy[r] = busy[r] & !(clear & wb_reg == r). A same-cycle retire resolves the hazard.
- stall = issue_valid & !flush & ((issue_use1 & eff_busy[rreg1]) | (issue_use2 & eff_busy[rreg2]) | (issue_wr & eff_busy[wreg])).
- accept = issue_valid & !stall & !flush. If accept & issue_wr (and not the zero register), busy[issue_wreg] <= 1.
- Same register set and cleared in one cycle: the set wins, so the bit stays 1.
- flush: at the edge, busy_vec <= 0 and no issue is accepted. Register data is untouched. A commit in the same cycle still writes data. stall = 0 during flush.
- Writeback to a non-busy register (stale after flush) still commits data. The clear has no effect.
- pend_cnt is updated in the same edge as busy_vec and always equals popcount(busy_vec). Its maximum is NREGS (or NREGS-1 with ZERO_REG).
- Latency: data written at edge N is readable from the array in cycle N+1. Via the bypass it is readable in cycle N.
- Reset asserted mid-operation: pending producers are lost. Later writebacks behave as stale writebacks.

Test Plan:
- Reset then read: rst low, then high. issue_rreg1=3, issue_rreg2=5 -> rd1 = rd2 = 0x0000, busy_vec = 0, pend_cnt = 0, stall = 0.
- Write/bypass: commit wb_reg=2, wb_data=0xBEEF while issue_rreg1=2 -> rd1 = 0xBEEF in the same cycle and the following cycle.
- Skip/dirty protection: wb_valid=1, wb_skip=1, wb_reg=4, data 0x1234, with busy[4]=1 -> regs[4] unchanged (0), busy[4] cleared, pend_cnt decrements.
- RAW stall: issue writes r1 (accepted, busy_vec = 0x02). Next issue reads r1 -> stall = 1 until the cycle wb_valid retires r1. In that cycle stall = 0 and rd1 = wb_data.
- WAW plus simultaneous set/clear: r6 busy. Issue writing r6 in the same cycle wb retires r6 -> accepted, busy[6] stays 1, pend_cnt unchanged.
- Flush and ZERO_REG=1: issue r3 and r5 (pend_cnt = 2), then flush with an issue present -> busy_vec = 0, pend_cnt = 0, issue not accepted. Issue writing r0 -> busy[0] never set. Commit to r0 with 0xFFFF -> rd reads 0.
